// File: rtl/frame_serializer.sv
// Frame serializer: captures one parallel frame into a private buffer and replays it
// one sample per beat over a valid/ready stream, with zero-bubble back-to-back frames.
module frame_serializer #(
  parameter int FRAME_LEN = 256,
  parameter int SAMPLE_W  = 12,
  parameter int IDX_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] frame_in [0:FRAME_LEN-1],
  input  logic                frame_valid,
  output logic                frame_accept,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [IDX_W-1:0]    sample_idx,
  output logic                sample_last,
  output logic                busy,
  output logic                frame_drop
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t              state_r;
  logic [IDX_W-1:0]    idx_r;
  logic [SAMPLE_W-1:0] buf_r [0:FRAME_LEN-1];
  logic [SAMPLE_W-1:0] sample_out_r;
  logic                sample_valid_r;
  logic                sample_last_r;
  logic                busy_r;
  logic                frame_drop_r;

  logic                beat_s;
  logic                last_s;
  logic                frame_accept_s;
  logic                capture_s;
  logic [IDX_W-1:0]    idx_next_s;

  // Handshake decode; frame_accept is the single combinational input-to-output path.
  always_comb begin
    beat_s         = sample_valid_r & sample_ready;
    last_s         = (idx_r == LAST_IDX);
    idx_next_s     = idx_r + IDX_W'(1);
    frame_accept_s = 1'b0;
    case (state_r)
      IDLE:    frame_accept_s = 1'b1;
      STREAM:  frame_accept_s = beat_s & last_s;
      default: frame_accept_s = 1'b0;
    endcase
    capture_s = frame_valid & frame_accept_s;
  end

  // Frame buffer, index counter, FSM state and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      idx_r          <= {IDX_W{1'b0}};
      sample_out_r   <= {SAMPLE_W{1'b0}};
      sample_valid_r <= 1'b0;
      sample_last_r  <= 1'b0;
      busy_r         <= 1'b0;
      frame_drop_r   <= 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        buf_r[i] <= {SAMPLE_W{1'b0}};
      end
    end else begin
      frame_drop_r <= frame_valid & ~frame_accept_s;
      if (capture_s) begin
        // Sample 0 is taken straight from frame_in since buf_r updates at this same edge.
        for (int i = 0; i < FRAME_LEN; i++) begin
          buf_r[i] <= frame_in[i];
        end
        state_r        <= STREAM;
        idx_r          <= {IDX_W{1'b0}};
        sample_out_r   <= frame_in[0];
        sample_valid_r <= 1'b1;
        sample_last_r  <= (LAST_IDX == {IDX_W{1'b0}});
        busy_r         <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          STREAM: begin
            if (beat_s && last_s) begin
              state_r        <= IDLE;
              idx_r          <= {IDX_W{1'b0}};
              sample_out_r   <= {SAMPLE_W{1'b0}};
              sample_valid_r <= 1'b0;
              sample_last_r  <= 1'b0;
              busy_r         <= 1'b0;
            end else if (beat_s) begin
              idx_r         <= idx_next_s;
              sample_out_r  <= buf_r[idx_next_s];
              sample_last_r <= (idx_next_s == LAST_IDX);
            end else begin
              state_r <= STREAM;
            end
          end
          default: begin
            state_r        <= IDLE;
            idx_r          <= {IDX_W{1'b0}};
            sample_out_r   <= {SAMPLE_W{1'b0}};
            sample_valid_r <= 1'b0;
            sample_last_r  <= 1'b0;
            busy_r         <= 1'b0;
          end
        endcase
      end
    end
  end

  assign frame_accept = frame_accept_s;
  assign sample_out   = sample_out_r;
  assign sample_valid = sample_valid_r;
  assign sample_idx   = idx_r;
  assign sample_last  = sample_last_r;
  assign busy         = busy_r;
  assign frame_drop   = frame_drop_r;

endmodule
